// File: rtl/prog_loader.sv
// prog_loader: manual program loader and memory inspector.
// It takes the RAM bus while the CPU controller sits in LOAD or CHECK.
// Each debounced A1 press becomes one write cycle (LOAD) or one read cycle
// (CHECK) at the current address. The address then auto-increments.
module prog_loader #(
  parameter int ADDR_W   = 16,
  parameter int DEBOUNCE = 4,
  parameter int STROBE   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        cpustate,
  input  logic              A1,
  input  logic [7:0]        D,
  input  logic [7:0]        mem_rdata,
  output logic [ADDR_W-1:0] addr,
  output logic [7:0]        wdata,
  output logic              read,
  output logic              write,
  output logic              own,
  output logic              busy,
  output logic [7:0]        check_out
);

  localparam logic [1:0] CS_LOAD  = 2'b01;
  localparam logic [1:0] CS_CHECK = 2'b10;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_STROBE = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  localparam int DBW = $clog2(DEBOUNCE + 1);
  localparam int SW  = $clog2(STROBE + 1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE - 1);
  localparam logic [SW-1:0]  SB_LAST = SW'(STROBE - 1);

  logic           sync_p0;
  logic           sync_p1;
  logic           deb_level;
  logic           deb_level_q;
  logic [DBW-1:0] deb_cnt;
  logic [1:0]     settle_cnt;
  logic           armed;
  logic           press;
  logic [1:0]     cs_q;
  logic           cs_change;
  logic [1:0]     state;
  logic [SW-1:0]  strobe_cnt;
  logic           mode_load;

  // The bus belongs to the loader only in LOAD and CHECK.
  // The strobes are gated by that, so they can never leak onto the CPU's bus.
  assign own       = (cpustate == CS_LOAD) || (cpustate == CS_CHECK);
  assign cs_change = (cpustate != cs_q);
  assign busy      = (state != S_IDLE);
  assign read      = own && (state == S_STROBE) && !mode_load;
  assign write     = own && (state == S_STROBE) &&  mode_load;

  // A press needs a debounced rising edge.
  // It also needs the key to have been seen released at least once since reset.
  assign press = deb_level && !deb_level_q && armed;

  // Two-flop synchronizer for the asynchronous key.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= A1;
      sync_p1 <= sync_p0;
    end
  end

  // Debouncer: the level flips only after DEBOUNCE consecutive disagreeing cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      deb_level   <= 1'b0;
      deb_level_q <= 1'b0;
      deb_cnt     <= '0;
    end else begin
      deb_level_q <= deb_level;
      if (sync_p1 == deb_level) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DB_LAST) begin
        deb_level <= ~deb_level;
        deb_cnt   <= '0;
      end else begin
        deb_cnt <= deb_cnt + DBW'(1);
      end
    end
  end

  // Arming: a key already held through reset must not count as a press.
  // settle_cnt waits for the synchronizer to fill with real samples.
  // Arming then waits for a released, debounced-low key.
  always_ff @(posedge clk) begin
    if (rst) begin
      settle_cnt <= 2'd0;
      armed      <= 1'b0;
    end else begin
      if (settle_cnt != 2'd2) settle_cnt <= settle_cnt + 2'd1;
      if (settle_cnt == 2'd2 && !sync_p1 && !deb_level) armed <= 1'b1;
    end
  end

  // Access sequencer: IDLE -> SETUP -> STROBE x N -> FINISH -> IDLE.
  // Any cpustate change aborts the access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      strobe_cnt <= '0;
      mode_load  <= 1'b0;
      cs_q       <= 2'b00;
      addr       <= '0;
      wdata      <= 8'h00;
      check_out  <= 8'h00;
    end else begin
      cs_q <= cpustate;
      if (cs_change) begin
        // A mode change wins over a same-cycle press.
        // It restarts addressing from zero, and the aborted access leaves no trace.
        state      <= S_IDLE;
        strobe_cnt <= '0;
        if (busy || own) addr <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (press && own) begin
              wdata     <= D;
              mode_load <= (cpustate == CS_LOAD);
              state     <= S_SETUP;
            end
          end
          S_SETUP: begin
            strobe_cnt <= '0;
            state      <= S_STROBE;
          end
          S_STROBE: begin
            if (strobe_cnt == SB_LAST) begin
              check_out <= mode_load ? wdata : mem_rdata;
              state     <= S_FINISH;
            end else begin
              strobe_cnt <= strobe_cnt + SW'(1);
            end
          end
          S_FINISH: begin
            addr  <= addr + ADDR_W'(1);
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed testbench for prog_loader.
// Three instances share every input:
//   - the default 16-bit instance,
//   - a 4-bit address instance for wrap-around,
//   - a long-strobe instance that makes a press during busy possible.
module tb_prog_loader;

  localparam int DB  = 4;
  localparam int SB  = 2;
  localparam int SBL = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       A1;
  logic [1:0] cpustate;
  logic [7:0] D;
  logic [7:0] mem_rdata;
  logic [7:0] ram [0:255];

  logic [15:0] a16;
  logic [7:0]  wd16, co16;
  logic        rd16, wr16, own16, busy16;
  logic [3:0]  a4;
  logic [7:0]  wd4, co4;
  logic        rd4, wr4, own4, busy4;
  logic [15:0] al;
  logic [7:0]  wdl, col;
  logic        rdl, wrl, ownl, busyl;

  int checks = 0;
  int errors = 0;

  assign mem_rdata = ram[a16[7:0]];

  always #5 clk = ~clk;

  prog_loader #(.ADDR_W(16), .DEBOUNCE(DB), .STROBE(SB)) dut (
    .clk(clk), .rst(rst), .cpustate(cpustate), .A1(A1), .D(D), .mem_rdata(mem_rdata),
    .addr(a16), .wdata(wd16), .read(rd16), .write(wr16), .own(own16), .busy(busy16),
    .check_out(co16));

  prog_loader #(.ADDR_W(4), .DEBOUNCE(DB), .STROBE(SB)) dut_w (
    .clk(clk), .rst(rst), .cpustate(cpustate), .A1(A1), .D(D), .mem_rdata(mem_rdata),
    .addr(a4), .wdata(wd4), .read(rd4), .write(wr4), .own(own4), .busy(busy4),
    .check_out(co4));

  prog_loader #(.ADDR_W(16), .DEBOUNCE(DB), .STROBE(SBL)) dut_l (
    .clk(clk), .rst(rst), .cpustate(cpustate), .A1(A1), .D(D), .mem_rdata(mem_rdata),
    .addr(al), .wdata(wdl), .read(rdl), .write(wrl), .own(ownl), .busy(busyl),
    .check_out(col));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // One press held for 'hold' cycles.
  // After step k the bench observes cycle R+k, where R is the first edge that samples A1 high.
  // The press is accepted at E = R+2+DB.
  task automatic access(input logic [7:0] d, input int hold, input logic ld,
                        input logic [15:0] ea, input logic [7:0] ec);
    logic [15:0] ea1;
    logic [3:0]  ea4, ea41;
    ea1  = ea + 16'd1;
    ea4  = ea[3:0];
    ea41 = ea4 + 4'd1;
    D  = d;
    A1 = 1'b1;
    for (int k = 1; k <= 5 + DB + SB; k++) begin
      step();
      if (k == hold) A1 = 1'b0;
      if (k == 2 + DB) begin
        checks++;
        if ({busy16, busy4} !== 2'b00) begin
          errors++;
          $display("FAIL early_busy @%0h got %b want 00", ea, {busy16, busy4});
        end
      end
      if (k == 3 + DB) begin
        checks++;
        if ({busy16, rd16, wr16, busy4, rd4, wr4} !== 6'b100100) begin
          errors++;
          $display("FAIL setup_ctl @%0h got %b want 100100", ea, {busy16, rd16, wr16, busy4, rd4, wr4});
        end
        checks++;
        if ({a16, a4, wd16, wd4} !== {ea, ea4, d, d}) begin
          errors++;
          $display("FAIL setup_bus got %h/%h/%h/%h want %h/%h/%h/%h", a16, a4, wd16, wd4, ea, ea4, d, d);
        end
      end
      if (k >= 4 + DB && k <= 3 + DB + SB) begin
        checks++;
        if ({busy16, rd16, wr16, busy4, rd4, wr4} !== {1'b1, ~ld, ld, 1'b1, ~ld, ld}) begin
          errors++;
          $display("FAIL strobe @%0h k=%0d got %b want %b", ea, k,
                   {busy16, rd16, wr16, busy4, rd4, wr4}, {1'b1, ~ld, ld, 1'b1, ~ld, ld});
        end
        checks++;
        if ({a16, a4} !== {ea, ea4}) begin
          errors++;
          $display("FAIL strobe_addr got %h/%h want %h/%h", a16, a4, ea, ea4);
        end
      end
      if (k == 4 + DB + SB) begin
        checks++;
        if ({busy16, rd16, wr16} !== 3'b100) begin
          errors++;
          $display("FAIL finish_ctl @%0h got %b want 100", ea, {busy16, rd16, wr16});
        end
        checks++;
        if ({co16, co4} !== {ec, ec}) begin
          errors++;
          $display("FAIL check_out @%0h got %h/%h want %h", ea, co16, co4, ec);
        end
      end
      if (k == 5 + DB + SB) begin
        checks++;
        if ({busy16, busy4} !== 2'b00) begin
          errors++;
          $display("FAIL end_busy @%0h got %b want 00", ea, {busy16, busy4});
        end
        checks++;
        if ({a16, a4} !== {ea1, ea41}) begin
          errors++;
          $display("FAIL addr_inc got %h/%h want %h/%h", a16, a4, ea1, ea41);
        end
      end
    end
    A1 = 1'b0;
  endtask

  task automatic test_reset();
    logic seen;
    rst = 1'b1; A1 = 1'b1; D = 8'hFF; cpustate = 2'b01;
    step();
    checks++;
    if ({a16, wd16, co16, rd16, wr16, busy16} !== 35'd0) begin
      errors++;
      $display("FAIL reset_hold got a=%h wd=%h co=%h r=%b w=%b b=%b want 0", a16, wd16, co16, rd16, wr16, busy16);
    end
    step();
    rst = 1'b0;
    step();
    checks++;
    if ({a16, wd16, co16, rd16, wr16, busy16} !== 35'd0) begin
      errors++;
      $display("FAIL reset_release got a=%h wd=%h co=%h r=%b w=%b b=%b want 0", a16, wd16, co16, rd16, wr16, busy16);
    end
    checks++;
    if ({own16, own4, ownl} !== 3'b111) begin
      errors++;
      $display("FAIL own_load got %b want 111", {own16, own4, ownl});
    end
    seen = 1'b0;
    for (int i = 0; i < 14; i++) begin
      step();
      if (busy16 || wr16) seen = 1'b1;
    end
    A1 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (busy16 || wr16) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL held_key_press got %b want 0", seen);
    end
    checks++;
    if (a16 !== 16'h0000) begin
      errors++;
      $display("FAIL held_key_addr got %h want 0000", a16);
    end
  endtask

  task automatic test_load();
    cpustate = 2'b01;
    access(8'h3E, DB + 1, 1'b1, 16'h0000, 8'h3E); idle(3);
    access(8'h12, DB + 1, 1'b1, 16'h0001, 8'h12); idle(3);
    access(8'hA5, DB + 1, 1'b1, 16'h0002, 8'hA5); idle(3);
    checks++;
    if ({a16, co16} !== {16'h0003, 8'hA5}) begin
      errors++;
      $display("FAIL load_final got %h/%h want 0003/a5", a16, co16);
    end
  endtask

  task automatic test_check();
    ram[0] = 8'h3E; ram[1] = 8'h12; ram[2] = 8'hA5;
    cpustate = 2'b10;
    idle(3);
    checks++;
    if (a16 !== 16'h0000) begin
      errors++;
      $display("FAIL check_entry_addr got %h want 0000", a16);
    end
    access(8'h00, DB + 1, 1'b0, 16'h0000, 8'h3E); idle(3);
    access(8'h00, DB + 1, 1'b0, 16'h0001, 8'h12); idle(3);
    access(8'h00, DB + 1, 1'b0, 16'h0002, 8'hA5); idle(3);
  endtask

  task automatic test_debounce();
    logic seen;
    cpustate = 2'b01;
    idle(3);
    seen = 1'b0;
    for (int p = 0; p < 2; p++) begin
      A1 = 1'b1;
      for (int i = 0; i < DB - 1; i++) begin
        step();
        if (busy16) seen = 1'b1;
      end
      A1 = 1'b0;
      for (int i = 0; i < 12; i++) begin
        step();
        if (busy16) seen = 1'b1;
      end
    end
    checks++;
    if ({seen, a16} !== {1'b0, 16'h0000}) begin
      errors++;
      $display("FAIL short_pulse got busy_seen=%b a=%h want 0/0000", seen, a16);
    end
    access(8'h4C, DB + 3, 1'b1, 16'h0000, 8'h4C);
    idle(20);
    checks++;
    if ({al, busyl} !== {16'h0001, 1'b0}) begin
      errors++;
      $display("FAIL long_first got a=%h b=%b want 0001/0", al, busyl);
    end
    // The second press lands while the long-strobe instance is still busy.
    access(8'h91, DB + 1, 1'b1, 16'h0001, 8'h91);
    access(8'hC3, DB + 1, 1'b1, 16'h0002, 8'hC3);
    idle(25);
    checks++;
    if ({al, busyl, rdl, wrl} !== {16'h0002, 3'b000}) begin
      errors++;
      $display("FAIL drop_addr got a=%h ctl=%b want 0002/000", al, {busyl, rdl, wrl});
    end
    checks++;
    if ({wdl, col} !== {8'h91, 8'h91}) begin
      errors++;
      $display("FAIL drop_data got %h/%h want 91/91", wdl, col);
    end
  endtask

  task automatic test_abort();
    D = 8'h5A; A1 = 1'b1;
    for (int k = 1; k <= 4 + DB; k++) begin
      step();
      if (k == DB + 1) A1 = 1'b0;
    end
    checks++;
    if ({busy16, wr16, a16} !== {2'b11, 16'h0003}) begin
      errors++;
      $display("FAIL abort_pre got b=%b w=%b a=%h want 1/1/0003", busy16, wr16, a16);
    end
    cpustate = 2'b11;
    step();
    checks++;
    if ({busy16, rd16, wr16, own16, own4, ownl} !== 6'b000000) begin
      errors++;
      $display("FAIL abort_ctl got %b want 000000", {busy16, rd16, wr16, own16, own4, ownl});
    end
    checks++;
    if ({a16, co16} !== {16'h0000, 8'hC3}) begin
      errors++;
      $display("FAIL abort_state got %h/%h want 0000/c3", a16, co16);
    end
    idle(6);
    checks++;
    if ({a16, co16, busy16} !== {16'h0000, 8'hC3, 1'b0}) begin
      errors++;
      $display("FAIL abort_after got %h/%h/%b want 0000/c3/0", a16, co16, busy16);
    end
  endtask

  task automatic test_wrap();
    cpustate = 2'b01;
    idle(3);
    for (int i = 0; i < 17; i++) begin
      access(8'(i), DB + 1, 1'b1, 16'(i), 8'(i));
      idle(3);
    end
    checks++;
    if ({a4, a16, co4} !== {4'h1, 16'h0011, 8'h10}) begin
      errors++;
      $display("FAIL wrap_final got %h/%h/%h want 1/0011/10", a4, a16, co4);
    end
  endtask

  task automatic test_reset_mid();
    D = 8'hEE; A1 = 1'b1;
    for (int k = 1; k <= 4 + DB; k++) begin
      step();
      if (k == DB + 1) A1 = 1'b0;
    end
    checks++;
    if (wr16 !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre got w=%b want 1", wr16);
    end
    rst = 1'b1;
    step();
    checks++;
    if ({a16, wd16, co16, busy16, rd16, wr16} !== 35'd0) begin
      errors++;
      $display("FAIL rstmid got a=%h wd=%h co=%h ctl=%b want 0", a16, wd16, co16, {busy16, rd16, wr16});
    end
    rst = 1'b0;
    idle(2);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    test_reset();
    test_load();
    test_check();
    test_debounce();
    test_abort();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Manual program loader and memory inspector for the 8-bit machine. When the CPU controller selects LOAD or CHECK state, it acts as the bus initiator on the RAM port in place of the CPU. It turns debounced presses of the A1 key into single write cycles (switch byte D to the next address) or single read cycles (next address to `check_out`), then auto-increments the address. It sits beside `cpu` and drives the same `addr`/`read`/`write`/data nets through the top-level mux selected by `own`.

## Interface
- ADDR_W, 16, address width; wraps modulo 2^ADDR_W
- DEBOUNCE, 4, consecutive stable cycles required to accept a level change on A1 (≥1)
- STROBE, 2, cycles `read`/`write` stay high per access (≥1; covers slower RAM clock)
- clk  in  1  system clock; single clock domain
- rst  in  1  synchronous, active-high reset
- cpustate  in  2  00 IDLE, 01 LOAD, 10 CHECK, 11 RUN
- A1  in  1  raw push key, asynchronous, active-high
- D  in  8  switch data byte
- mem_rdata  in  8  RAM read data
- addr  out  ADDR_W  RAM address
- wdata  out  8  RAM write data
- read  out  1  RAM read strobe
- write  out  1  RAM write strobe
- own  out  1  high in LOAD/CHECK; top mux gives bus to loader
- busy  out  1  access in progress
- check_out  out  8  last byte read (CHECK) or written (LOAD)

## Operation
- A1 passes through a 2-FF synchronizer, then the debouncer: a counter runs while the synced level differs from the debounced level. It clears on match. When it reaches DEBOUNCE, the debounced level flips. `press` is a 1-cycle pulse on the debounced 0→1 edge.
- FSM states: IDLE → SETUP → STROBE (STROBE cycles) → FINISH → IDLE.
- IDLE with `press` and cpustate ∈ {LOAD, CHECK}: latch D into `wdata`, latch the mode, go to SETUP.
- SETUP: addr and wdata stable; strobes low.
- STROBE: `write`=1 (LOAD) or `read`=1 (CHECK) for exactly STROBE cycles.
- CHECK: `check_out` ← mem_rdata, sampled on the last STROBE cycle.
- LOAD: `check_out` ← wdata at the end of the last STROBE cycle.
- FINISH: strobes low; at the end of FINISH, addr ← addr+1 modulo 2^ADDR_W (0xFFFF → 0x0000).
- `press` while busy is dropped, not queued.
- `press` in IDLE/RUN state is ignored.
- cpustate change (any transition) mid-access aborts the access: next cycle strobes are 0, FSM goes to IDLE, and addr ← 0. An aborted access never updates check_out or increments addr.
- Entering LOAD or CHECK from any other state sets addr ← 0. LOAD↔CHECK switching also resets addr to 0.
- `own` = combinational (cpustate==01 || cpustate==10). read/write are never high when `own`=0.

## Timing
- Reset values: addr=0, wdata=0, read=0, write=0, busy=0, check_out=0, FSM=IDLE, debounced level=0, debounce counter=0, synchronizer=0.
- A1 rise held stable → `press` high in cycle R+2+DEBOUNCE, where R is the first cycle A1 is high at the clock edge.
- A pulse shorter than DEBOUNCE cycles after synchronization produces no `press`.
- Press accepted in cycle E:
  - E+1: SETUP, busy=1.
  - E+2 … E+1+STROBE: strobe high.
  - E+2+STROBE: FINISH, check_out valid, busy=1.
  - E+3+STROBE: IDLE, busy=0, addr incremented.
- Minimum spacing between accepted accesses: STROBE+3 cycles.
- `press` and a cpustate change in the same cycle: the mode change wins, and no access starts.
- rst asserted mid-access: next cycle all outputs are at reset values, with no partial strobe extension.

## Test plan
- Reset: hold rst 2 cycles with A1=1 and D=0xFF → addr=0, read=write=busy=0, check_out=0. No press is generated until A1 goes low and then high again.
- LOAD three bytes:
  - Stimulus: cpustate=01; press with D=0x3E, 0x12, 0xA5.
  - Required: write pulses of STROBE cycles at addr 0, 1, 2 carrying those data; final addr=3; check_out=0xA5.
- CHECK readback:
  - Stimulus: RAM model preloaded [0x3E, 0x12, 0xA5]; cpustate=10; three presses.
  - Required: read strobes at addr 0, 1, 2; check_out=0x3E, then 0x12, then 0xA5, each valid at E+2+STROBE.
- Debounce: A1 pulses of DEBOUNCE−1 cycles → no access. A pulse of DEBOUNCE+3 cycles → exactly one access. A second clean press during busy → dropped, so addr advances by 1 only.
- Abort: cpustate 01→11 during the first STROBE cycle → write low next cycle, busy=0, own=0, addr=0, check_out unchanged.
- Wrap:
  - Setup: ADDR_W=4, LOAD, 16 presses with D=0x00…0x0F.
  - Required: 16th write at addr 0xF, addr wraps to 0x0. A 17th press writes at addr 0x0.
